ahb_fetch_data_arbiter: RTL

Shares the single AHB-Lite master port of the core between the instruction-fetch requester and the data (load/store) requester. It issues one non-pipelined AHB-Lite transfer at a time. Data requests have fixed priority, with a starvation guard that guarantees fetch progress. Sits between the IF and MEM stages and the system bus; its fetch-side status feeds the pipeline's combined stall.

---
 rtl/ahb_fetch_data_arbiter_pkg.sv | 29 ++
 rtl/ahb_fetch_data_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ahb_fetch_data_arbiter_pkg.sv
// Core-wide AHB-Lite bus definitions shared by the fetch/data arbiter.
// Holds transfer encodings, arbiter state/owner enums and the priority rule.
package ahb_fetch_data_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // Data has priority unless fetch has been passed over too many times.
  function automatic logic data_wins(input logic d_req, input logic if_req,
                                     input logic fetch_starved);
    return d_req && !(if_req && fetch_starved);
  endfunction

endpackage

// File: rtl/ahb_fetch_data_arbiter.sv
// Shares the core's single AHB-Lite master port between instruction fetch and
// load/store, one non-pipelined transfer at a time, data-first with a fetch starvation guard.
module ahb_fetch_data_arbiter
  import ahb_fetch_data_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_write,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        stall_if,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  arb_state_e  state_r, state_nxt_s;
  owner_e      owner_r, owner_nxt_s;
  logic [3:0]  starve_cnt_r, starve_nxt_s;
  logic [31:0] haddr_nxt_s, hwdata_nxt_s;
  logic [1:0]  htrans_nxt_s;
  logic        hwrite_nxt_s;
  logic [2:0]  hsize_nxt_s;
  logic        pick_data_s;
  logic        xfer_accept_s;
  logic        xfer_done_s;

  // Next-state, bus-output and starvation-counter computation.
  always_comb begin
    state_nxt_s  = state_r;
    owner_nxt_s  = owner_r;
    haddr_nxt_s  = HADDR;
    htrans_nxt_s = HTRANS;
    hwrite_nxt_s = HWRITE;
    hsize_nxt_s  = HSIZE;
    hwdata_nxt_s = HWDATA;
    // A fetch that is not waiting cannot be starving.
    starve_nxt_s = if_req ? starve_cnt_r : 4'd0;
    pick_data_s  = data_wins(d_req, if_req, starve_cnt_r == STARVE_MAX);

    case (state_r)
      ST_IDLE: begin
        if (d_req || if_req) begin
          state_nxt_s  = ST_ADDR;
          htrans_nxt_s = HTRANS_NONSEQ;
          if (pick_data_s) begin
            owner_nxt_s  = OWN_DATA;
            haddr_nxt_s  = d_addr;
            hwrite_nxt_s = d_write;
            hsize_nxt_s  = d_size;
            if (if_req && (starve_cnt_r != STARVE_MAX)) begin
              starve_nxt_s = starve_cnt_r + 4'd1;
            end else begin
              starve_nxt_s = if_req ? starve_cnt_r : 4'd0;
            end
          end else begin
            owner_nxt_s  = OWN_FETCH;
            haddr_nxt_s  = if_addr;
            hwrite_nxt_s = 1'b0;
            hsize_nxt_s  = HSIZE_WORD;
            starve_nxt_s = 4'd0;
          end
        end else begin
          htrans_nxt_s = HTRANS_IDLE;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          state_nxt_s  = ST_DATA;
          htrans_nxt_s = HTRANS_IDLE;
          if (owner_r == OWN_DATA) begin
            hwdata_nxt_s = d_wdata;
          end else begin
            hwdata_nxt_s = HWDATA;
          end
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        htrans_nxt_s = HTRANS_IDLE;
      end
    endcase
  end

  // State, owner, counter and registered AHB master outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_FETCH;
      starve_cnt_r <= 4'd0;
      HADDR        <= 32'h0000_0000;
      HTRANS       <= HTRANS_IDLE;
      HWRITE       <= 1'b0;
      HSIZE        <= HSIZE_WORD;
      HWDATA       <= 32'h0000_0000;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      starve_cnt_r <= starve_nxt_s;
      HADDR        <= haddr_nxt_s;
      HTRANS       <= htrans_nxt_s;
      HWRITE       <= hwrite_nxt_s;
      HSIZE        <= hsize_nxt_s;
      HWDATA       <= hwdata_nxt_s;
    end
  end

  // Handshakes are gated by state, so an asynchronous reset silences them at once.
  assign xfer_accept_s = (state_r == ST_ADDR) && HREADY;
  assign xfer_done_s   = (state_r == ST_DATA) && HREADY;

  assign if_gnt   = xfer_accept_s && (owner_r == OWN_FETCH);
  assign d_gnt    = xfer_accept_s && (owner_r == OWN_DATA);
  assign if_done  = xfer_done_s && (owner_r == OWN_FETCH);
  assign d_done   = xfer_done_s && (owner_r == OWN_DATA);
  assign if_err   = if_done && HRESP;
  assign d_err    = d_done && HRESP;
  assign if_rdata = if_done ? HRDATA : 32'h0000_0000;
  assign d_rdata  = d_done ? HRDATA : 32'h0000_0000;
  assign stall_if = if_req && !if_done;

endmodule
